peripheral_mpram_wb_arbiter: RTL

- Round-robin Wishbone arbiter that shares one single-port RAM Wishbone slave (peripheral_spram_wb) between NUM_MASTERS requesters.
- Burst-aware: a master keeps the grant until it drops wb_cyc, so classic and incrementing/wrapping bursts are never split.
- Forces at least one idle cycle (s_cyc_o=0) between owners. The RAM therefore always detects a new cycle and reloads its address from wb_adr.
- Sits between the CPU/DMA/NoC adapters and the RAM in the MPRAM tile.

---
 rtl/peripheral_mpram_wb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/peripheral_mpram_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one single-port RAM slave between NUM_MASTERS masters.
// Ownership lasts until the owner drops cyc, and owners are always separated by an idle cycle.
module peripheral_mpram_wb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DW          = 32,
    parameter int AW          = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [DW-1:0]             m_dat_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [1:0]                s_bte_o,
    output logic [2:0]                s_cti_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic [DW-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [LW-1:0]          last, last_nxt;
    logic [LW-1:0]          pick;
    logic                   pick_vld;
    logic [LW-1:0]          scan;
    int                     scan_sum;

    logic [AW-1:0] adr_arr [NUM_MASTERS];
    logic [DW-1:0] dat_arr [NUM_MASTERS];
    logic [3:0]    sel_arr [NUM_MASTERS];
    logic [1:0]    bte_arr [NUM_MASTERS];
    logic [2:0]    cti_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign adr_arr[g] = m_adr_i[g*AW +: AW];
        assign dat_arr[g] = m_dat_i[g*DW +: DW];
        assign sel_arr[g] = m_sel_i[g*4 +: 4];
        assign bte_arr[g] = m_bte_i[g*2 +: 2];
        assign cti_arr[g] = m_cti_i[g*3 +: 3];
    end

    // Scan from the farthest offset down so the requester closest after 'last' wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan     = '0;
        scan_sum = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            scan_sum = int'(last) + k;
            if (scan_sum >= NUM_MASTERS) begin
                scan_sum = scan_sum - NUM_MASTERS;
            end
            scan = LW'(scan_sum);
            if (m_cyc_i[scan]) begin
                pick     = scan;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            grant <= '0;
            last  <= LW'(NUM_MASTERS - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt       = OWNED;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    last_nxt        = pick;
                end
            end
            OWNED: begin
                if (!m_cyc_i[last]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // While owned, 'last' holds the current owner's index.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_bte_o = '0;
        s_cti_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state == OWNED) begin
            s_adr_o       = adr_arr[last];
            s_dat_o       = dat_arr[last];
            s_sel_o       = sel_arr[last];
            s_we_o        = m_we_i[last];
            s_bte_o       = bte_arr[last];
            s_cti_o       = cti_arr[last];
            s_cyc_o       = m_cyc_i[last];
            s_stb_o       = m_stb_i[last];
            m_ack_o[last] = s_ack_i;
            m_err_o[last] = s_err_i;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant;

endmodule
